// File: rtl/text_buffer_writer_pkg.sv
// Shared constants, ASCII codes and state/command encodings for the text-buffer writer.
package text_pkg;

   localparam int TXT_COLS   = 70;
   localparam int TXT_ROWS   = 30;
   localparam int TXT_ADDR_W = 12;

   localparam logic [7:0] CH_BS    = 8'h08;
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_FF    = 8'h0C;
   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_SP    = 8'h20;
   localparam logic [7:0] CH_TILDE = 8'h7E;

   typedef enum logic [1:0] {
      CLEAR    = 2'd0,
      IDLE     = 2'd1,
      LINE_CLR = 2'd2
   } state_e;

   typedef enum logic [2:0] {
      CUR_HOLD = 3'd0,
      CUR_ADV  = 3'd1,
      CUR_NL   = 3'd2,
      CUR_BS   = 3'd3,
      CUR_HOME = 3'd4
   } cur_cmd_e;

   function automatic logic is_printable(input logic [7:0] c);
      return (c >= CH_SP) && (c <= CH_TILDE);
   endfunction

endpackage

// File: rtl/text_buffer_writer_cursor_ctrl.sv
// Row/column cursor with advance, newline, backspace and home; exposes the
// registered linear address and the address it will take after this command.
module cursor_ctrl
   import text_pkg::*;
#(
   parameter int COLS   = TXT_COLS,
   parameter int ROWS   = TXT_ROWS,
   parameter int ADDR_W = TXT_ADDR_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  cur_cmd_e          cmd,
   output logic [ADDR_W-1:0] addr_q,
   output logic [ADDR_W-1:0] addr_d,
   output logic              row_adv
);

   localparam int COL_W = $clog2(COLS);
   localparam int ROW_W = $clog2(ROWS);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic [ROW_W-1:0] row_next;

   // The screen never scrolls: stepping past the last row lands on row 0.
   assign row_next = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);

   always_comb begin
      col_d   = col_q;
      row_d   = row_q;
      row_adv = 1'b0;
      case (cmd)
         CUR_ADV: begin
            if (col_q == COL_LAST) begin
               col_d   = '0;
               row_d   = row_next;
               row_adv = 1'b1;
            end else begin
               col_d = col_q + COL_W'(1);
            end
         end
         CUR_NL: begin
            col_d   = '0;
            row_d   = row_next;
            row_adv = 1'b1;
         end
         CUR_BS: begin
            if (col_q != '0) begin
               col_d = col_q - COL_W'(1);
            end else if (row_q != '0) begin
               row_d = row_q - ROW_W'(1);
               col_d = COL_LAST;
            end
         end
         CUR_HOME: begin
            col_d = '0;
            row_d = '0;
         end
         default: ;
      endcase
      addr_d = ADDR_W'(row_d) * ADDR_W'(COLS) + ADDR_W'(col_d);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         col_q  <= '0;
         row_q  <= '0;
         addr_q <= '0;
      end else begin
         col_q  <= col_d;
         row_q  <= row_d;
         addr_q <= addr_d;
      end
   end

endmodule

// File: rtl/text_buffer_writer.sv
// Character-RAM writer for the text display: screen clear, printable/newline/backspace/form-feed.
// Build option LINE_CLEAR_EN: blank each newly entered row before accepting more text.
module text_buffer_writer
   import text_pkg::*;
#(
   parameter int COLS   = TXT_COLS,
   parameter int ROWS   = TXT_ROWS,
   parameter int ADDR_W = TXT_ADDR_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              char_valid,
   input  logic [7:0]        char_in,
   output logic              char_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic [ADDR_W-1:0] cursor_addr,
   output logic              busy
);

   // state    | meaning
   // CLEAR    | sweep 0x00 over every cell, one per cycle
   // IDLE     | accept and decode one code per cycle
   // LINE_CLR | sweep 0x00 over the row the cursor just entered

   localparam logic [ADDR_W-1:0] CELL_LAST = ADDR_W'(COLS * ROWS - 1);
   localparam logic [ADDR_W-1:0] COL_LAST  = ADDR_W'(COLS - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]        wr_data_q, wr_data_d;
   logic              char_ready_q, char_ready_d;
   logic              busy_q, busy_d;

   cur_cmd_e          cur_cmd;
   logic [ADDR_W-1:0] cur_addr_q;
   logic [ADDR_W-1:0] cur_addr_nxt;
   logic              row_adv;
   logic              accept;

   cursor_ctrl #(
      .COLS   (COLS),
      .ROWS   (ROWS),
      .ADDR_W (ADDR_W)
   ) u_cursor (
      .clk     (clk),
      .reset_n (reset_n),
      .cmd     (cur_cmd),
      .addr_q  (cur_addr_q),
      .addr_d  (cur_addr_nxt),
      .row_adv (row_adv)
   );

`ifndef LINE_CLEAR_EN
   logic unused_row_adv;
   assign unused_row_adv = row_adv;
`endif

   assign accept = char_valid && char_ready_q;

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      cur_cmd   = CUR_HOLD;
      case (state_q)
         CLEAR: begin
            wr_en_d   = 1'b1;
            wr_addr_d = clr_cnt_q;
            wr_data_d = 8'h00;
            if (clr_cnt_q == CELL_LAST) begin
               clr_cnt_d = '0;
               state_d   = IDLE;
            end else begin
               clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            end
         end
         IDLE: begin
            if (accept) begin
               if (is_printable(char_in)) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = cur_addr_q;
                  wr_data_d = char_in;
                  cur_cmd   = CUR_ADV;
               end else if (char_in == CH_CR || char_in == CH_LF) begin
                  cur_cmd = CUR_NL;
               end else if (char_in == CH_BS) begin
                  // Backspace blanks the cell it moves onto, not the one it leaves.
                  wr_en_d   = 1'b1;
                  wr_addr_d = cur_addr_nxt;
                  wr_data_d = 8'h00;
                  cur_cmd   = CUR_BS;
               end else if (char_in == CH_FF) begin
                  cur_cmd   = CUR_HOME;
                  clr_cnt_d = '0;
                  state_d   = CLEAR;
               end
`ifdef LINE_CLEAR_EN
               if (row_adv) begin
                  clr_cnt_d = '0;
                  state_d   = LINE_CLR;
               end
`endif
            end
         end
`ifdef LINE_CLEAR_EN
         LINE_CLR: begin
            wr_en_d   = 1'b1;
            wr_addr_d = cur_addr_q + clr_cnt_q;
            wr_data_d = 8'h00;
            if (clr_cnt_q == COL_LAST) begin
               clr_cnt_d = '0;
               state_d   = IDLE;
            end else begin
               clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            end
         end
`endif
         default: begin
            clr_cnt_d = '0;
            state_d   = CLEAR;
         end
      endcase
      // Ready only while settled in IDLE; the cycle showing the last sweep write stays busy.
      char_ready_d = (state_q == IDLE) && (state_d == IDLE);
      busy_d       = !char_ready_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= CLEAR;
         clr_cnt_q    <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= 8'h00;
         char_ready_q <= 1'b0;
         busy_q       <= 1'b1;
      end else begin
         state_q      <= state_d;
         clr_cnt_q    <= clr_cnt_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         char_ready_q <= char_ready_d;
         busy_q       <= busy_d;
      end
   end

   assign char_ready  = char_ready_q;
   assign wr_en       = wr_en_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign cursor_addr = cur_addr_q;
   assign busy        = busy_q;

endmodule
